// File: rtl/rf_stream_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_stream_window                                                         |
// | Streaming F x F x D receptive-field generator fed one raster-order pixel |
// | per beat; windows leave on a valid/ready port at a configurable stride.  |
// | Optional: RF_STREAM_COORD_EN adds registered out_row/out_col ports.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rf_stream_window #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int STRIDE     = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [D*DATA_WIDTH-1:0]      in_pixel,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [D*F*F*DATA_WIDTH-1:0]  out_window,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         frame_done
`ifdef RF_STREAM_COORD_EN
    ,
    output logic [$clog2(H)-1:0]         out_row,
    output logic [$clog2(H)-1:0]         out_col
`endif
);

    localparam int PXW  = D * DATA_WIDTH;
    localparam int WINW = D * F * F * DATA_WIDTH;
    localparam int RW   = $clog2(H);
    localparam int CW   = $clog2(W);
    localparam int PW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [RW-1:0] c_row_last  = RW'(H - 1);
    localparam logic [RW-1:0] c_row_first = RW'(F - 1);
    localparam logic [CW-1:0] c_col_last  = CW'(W - 1);
    localparam logic [CW-1:0] c_col_first = CW'(F - 1);
    localparam logic [PW-1:0] c_ph_last   = PW'(STRIDE - 1);

    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [PW-1:0]   r_rph;
    logic [PW-1:0]   r_cph;
    logic [PXW-1:0]  r_lb [F-1][W];
    logic [WINW-1:0] r_win;
    logic [WINW-1:0] w_win_next;
    logic            r_out_valid;
    logic            r_frame_done;

    logic w_acc;
    logic w_col_last;
    logic w_row_last;
    logic w_row_ok;
    logic w_col_ok;
    logic w_win_done;

    assign in_ready   = reset_n && (!r_out_valid || out_ready);
    assign w_acc      = in_valid && in_ready;
    assign w_col_last = (r_col == c_col_last);
    assign w_row_last = (r_row == c_row_last);
    // Phase counters hold (pos - (F-1)) % STRIDE once pos has reached F-1.
    assign w_row_ok   = (r_row >= c_row_first) && (r_rph == '0);
    assign w_col_ok   = (r_col >= c_col_first) && (r_cph == '0);
    assign w_win_done = w_row_ok && w_col_ok;

    assign out_window = r_win;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;

    // Line buffer l holds row (r-1-l) at every column.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb[0][r_col] <= in_pixel;
            for (int l = 1; l < F - 1; l++) begin
                r_lb[l][r_col] <= r_lb[l-1][r_col];
            end
        end
    end

    always_comb begin
        w_win_next = r_win;
        for (int k = 0; k < D; k++) begin
            for (int i = 0; i < F; i++) begin
                for (int j = 0; j < F - 1; j++) begin
                    w_win_next[((k*F+i)*F+j)*DATA_WIDTH +: DATA_WIDTH] =
                        r_win[((k*F+i)*F+j+1)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int i = 0; i < F - 1; i++) begin
                w_win_next[((k*F+i)*F+F-1)*DATA_WIDTH +: DATA_WIDTH] =
                    r_lb[F-2-i][r_col][k*DATA_WIDTH +: DATA_WIDTH];
            end
            w_win_next[((k*F+F-1)*F+F-1)*DATA_WIDTH +: DATA_WIDTH] =
                in_pixel[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_rph        <= '0;
            r_cph        <= '0;
            r_win        <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_acc) begin
                r_win <= w_win_next;
                if (w_col_last) begin
                    r_col <= '0;
                    r_cph <= '0;
                    if (w_row_last) begin
                        r_row <= '0;
                        r_rph <= '0;
                    end else begin
                        r_row <= r_row + 1'b1;
                        if (r_row >= c_row_first) begin
                            r_rph <= (r_rph == c_ph_last) ? '0 : r_rph + 1'b1;
                        end
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                    if (r_col >= c_col_first) begin
                        r_cph <= (r_cph == c_ph_last) ? '0 : r_cph + 1'b1;
                    end
                end
            end
            if (w_acc && w_win_done) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_frame_done <= w_acc && w_col_last && w_row_last;
        end
    end

`ifdef RF_STREAM_COORD_EN
    logic [RW-1:0] r_orow_cnt;
    logic [RW-1:0] r_ocol_cnt;
    logic [RW-1:0] r_out_row;
    logic [RW-1:0] r_out_col;

    assign out_row = r_out_row;
    assign out_col = r_out_col;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_orow_cnt <= '0;
            r_ocol_cnt <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
        end else if (w_acc) begin
            if (w_win_done) begin
                r_out_row <= r_orow_cnt;
                r_out_col <= r_ocol_cnt;
            end
            if (w_col_last) begin
                r_ocol_cnt <= '0;
                if (w_row_last) begin
                    r_orow_cnt <= '0;
                end else if (w_row_ok) begin
                    r_orow_cnt <= r_orow_cnt + 1'b1;
                end
            end else if (w_col_ok) begin
                r_ocol_cnt <= r_ocol_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_stream_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rf_stream_window                                                      |
// | Bench for rf_stream_window: D=3/STRIDE=1 and D=1/STRIDE=2 instances.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rf_stream_window;

    localparam int DW     = 16;
    localparam int H      = 32;
    localparam int W      = 32;
    localparam int F      = 5;
    localparam int NPIX   = H * W;
    localparam int DA     = 3;
    localparam int WA     = DA * F * F * DW;
    localparam int WB     = F * F * DW;
    localparam int BUDGET = 8000;

    logic clk;
    logic rst_n;

    logic [DA*DW-1:0] a_pix;
    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_fd;
    logic [WA-1:0]    a_win;
    logic [DW-1:0]    b_pix;
    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_fd;
    logic [WB-1:0]    b_win;

    int compared = 0;
    int failed   = 0;

    logic [DW-1:0] img [DA][NPIX];
    logic [WA-1:0] qa_win[$];
    int            qa_cnt[$];
    int            qa_fd[$];
    logic [WA-1:0] qb_win[$];
    int            qb_cnt[$];
    int            qb_fd[$];
    int            a_acc = 0;
    int            b_acc = 0;

    rf_stream_window #(.DATA_WIDTH(DW), .D(DA), .H(H), .W(W), .F(F), .STRIDE(1)) u_dut_a (
        .clk(clk), .reset_n(rst_n), .in_pixel(a_pix), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_window(a_win), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .frame_done(a_fd)
    );

    rf_stream_window #(.DATA_WIDTH(DW), .D(1), .H(H), .W(W), .F(F), .STRIDE(2)) u_dut_b (
        .clk(clk), .reset_n(rst_n), .in_pixel(b_pix), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_window(b_win), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .frame_done(b_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitors: count accepts, log every consumed window with the accept count at that moment.
    always @(posedge clk) begin
        if (a_in_valid && a_in_ready) a_acc++;
        if (b_in_valid && b_in_ready) b_acc++;
    end

    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            qa_win.push_back(a_win);
            qa_cnt.push_back(a_acc);
        end
        if (a_fd) qa_fd.push_back(a_acc);
        if (b_out_valid && b_out_ready) begin
            qb_win.push_back({{(WA-WB){1'b0}}, b_win});
            qb_cnt.push_back(b_acc);
        end
        if (b_fd) qb_fd.push_back(b_acc);
    end

    // Reference window: element (k,i,j) is the image pixel at origin + (i,j) in channel k.
    function automatic logic [WA-1:0] exp_win(input int r0, input int c0, input int nd);
        logic [WA-1:0] v;
        v = '0;
        for (int k = 0; k < nd; k++)
            for (int i = 0; i < F; i++)
                for (int j = 0; j < F; j++)
                    v[((k*F+i)*F+j)*DW +: DW] = img[k][(r0+i)*W + c0 + j];
        return v;
    endfunction

    function automatic logic [DW-1:0] el(input logic [WA-1:0] w, input int k, input int i, input int j);
        return w[((k*F+i)*F+j)*DW +: DW];
    endfunction

    task automatic fill_ramp();
        for (int k = 0; k < DA; k++)
            for (int p = 0; p < NPIX; p++)
                img[k][p] = 16'(p + k * 1000);
    endtask

    task automatic fill_random();
        for (int k = 0; k < DA; k++)
            for (int p = 0; p < NPIX; p++)
                img[k][p] = 16'($urandom);
    endtask

    task automatic clear_mon();
        qa_win.delete(); qa_cnt.delete(); qa_fd.delete();
        qb_win.delete(); qb_cnt.delete(); qb_fd.delete();
        a_acc = 0;
        b_acc = 0;
    endtask

    // mode 0: streaming, 1: random valid/ready, 2: stall 10 cycles on first window.
    task automatic drive_a(input int mode, input int npix, input bit drain);
        int  idx   = 0;
        int  cyc   = 0;
        int  stall = 0;
        bit  acc;
        logic [WA-1:0] first_win;
        first_win = exp_win(0, 0, DA);
        while (idx < npix && cyc < BUDGET) begin
            a_in_valid  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            a_pix       = {img[2][idx], img[1][idx], img[0][idx]};
            a_out_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mode == 2 && stall < 10 && a_out_valid) begin
                a_out_ready = 1'b0;
                @(negedge clk);
                compared += 2;
                if (a_in_ready !== 1'b0) begin
                    failed++;
                    $display("FAIL stall_in_ready cycle %0d: got %b, expected 0", stall, a_in_ready);
                end
                if (a_win !== first_win) begin
                    failed++;
                    $display("FAIL stall_window cycle %0d: elem0 got %0h, expected %0h", stall, a_win[15:0], first_win[15:0]);
                end
                stall++;
            end else begin
                @(negedge clk);
            end
            acc = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        a_in_valid = 1'b0;
        if (idx < npix) begin
            compared++; failed++;
            $display("FAIL drive_a_timeout: accepted %0d, expected %0d", idx, npix);
        end
        if (drain) repeat (8) begin a_out_ready = 1'b1; @(posedge clk); #1; end
    endtask

    task automatic drive_b();
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < NPIX && cyc < BUDGET) begin
            b_in_valid  = 1'b1;
            b_pix       = img[0][idx];
            b_out_ready = 1'b1;
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        b_in_valid = 1'b0;
        if (idx < NPIX) begin
            compared++; failed++;
            $display("FAIL drive_b_timeout: accepted %0d, expected %0d", idx, NPIX);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input bit use_b, input int stride, input int nd);
        int n = 0;
        int nq, cnt, ecnt, nfd, fd0;
        logic [WA-1:0] e, got;
        nq  = use_b ? qb_win.size() : qa_win.size();
        nfd = use_b ? qb_fd.size() : qa_fd.size();
        for (int orow = 0; orow <= (H - F) / stride; orow++) begin
            for (int ocol = 0; ocol <= (W - F) / stride; ocol++) begin
                e    = exp_win(orow * stride, ocol * stride, nd);
                ecnt = (orow * stride + F - 1) * W + ocol * stride + F;
                if (n < nq) begin
                    got = use_b ? qb_win[n] : qa_win[n];
                    cnt = use_b ? qb_cnt[n] : qa_cnt[n];
                    compared++;
                    if (got !== e || cnt != ecnt) begin
                        failed++;
                        $display("FAIL %s window %0d (%0d,%0d): accepts %0d elem0 %0h, expected accepts %0d elem0 %0h",
                                 tag, n, orow, ocol, cnt, got[15:0], ecnt, e[15:0]);
                    end
                end
                n++;
            end
        end
        compared++;
        if (nq != n) begin
            failed++;
            $display("FAIL %s window_count: got %0d, expected %0d", tag, nq, n);
        end
        fd0 = (nfd > 0) ? (use_b ? qb_fd[0] : qa_fd[0]) : -1;
        compared++;
        if (nfd != 1 || fd0 != NPIX) begin
            failed++;
            $display("FAIL %s frame_done: pulses %0d at accepts %0d, expected 1 at %0d", tag, nfd, fd0, NPIX);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_pix = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_pix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared += 5;
        if (a_out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b, expected 0", a_out_valid); end
        if (a_win !== '0)         begin failed++; $display("FAIL reset_out_window: elem0 got %0h, expected 0", a_win[15:0]); end
        if (a_fd !== 1'b0)        begin failed++; $display("FAIL reset_frame_done: got %b, expected 0", a_fd); end
        if (a_in_ready !== 1'b0)  begin failed++; $display("FAIL reset_in_ready: got %b, expected 0", a_in_ready); end
        if (b_out_valid !== 1'b0) begin failed++; $display("FAIL reset_b_out_valid: got %b, expected 0", b_out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (a_in_ready !== 1'b1) begin failed++; $display("FAIL release_in_ready: got %b, expected 1", a_in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        logic [WA-1:0] w;
        fill_ramp();
        clear_mon();
        drive_a(0, NPIX, 1'b1);
        check_frame("ramp", 1'b0, 1, DA);
        w = (qa_win.size() > 0) ? qa_win[0] : '0;
        compared += 6;
        if (((qa_cnt.size() > 0) ? qa_cnt[0] : -1) != 133) begin failed++; $display("FAIL ramp_first_latency: got accepts %0d, expected 133", (qa_cnt.size() > 0) ? qa_cnt[0] : -1); end
        if (el(w, 0, 0, 0) !== 16'd0)    begin failed++; $display("FAIL ramp_e000: got %0d, expected 0", el(w, 0, 0, 0)); end
        if (el(w, 0, 1, 0) !== 16'd32)   begin failed++; $display("FAIL ramp_e010: got %0d, expected 32", el(w, 0, 1, 0)); end
        if (el(w, 0, 4, 4) !== 16'd132)  begin failed++; $display("FAIL ramp_e044: got %0d, expected 132", el(w, 0, 4, 4)); end
        if (el(w, 2, 0, 0) !== 16'd2000) begin failed++; $display("FAIL ramp_e200: got %0d, expected 2000", el(w, 2, 0, 0)); end
        if (el(w, 1, 4, 4) !== 16'd1132) begin failed++; $display("FAIL ramp_e144: got %0d, expected 1132", el(w, 1, 4, 4)); end
        w = (qa_win.size() > 280) ? qa_win[280] : '0;
        compared += 3;
        if (el(w, 0, 0, 0) !== 16'd320) begin failed++; $display("FAIL row10_e00: got %0d, expected 320", el(w, 0, 0, 0)); end
        if (el(w, 0, 0, 4) !== 16'd324) begin failed++; $display("FAIL row10_e04: got %0d, expected 324", el(w, 0, 0, 4)); end
        if (el(w, 0, 4, 4) !== 16'd452) begin failed++; $display("FAIL row10_e44: got %0d, expected 452", el(w, 0, 4, 4)); end
    endtask

    task automatic test_backpressure();
        fill_ramp();
        clear_mon();
        drive_a(2, NPIX, 1'b1);
        check_frame("backpressure", 1'b0, 1, DA);
    endtask

    task automatic test_random();
        fill_random();
        clear_mon();
        drive_a(1, NPIX, 1'b1);
        check_frame("random", 1'b0, 1, DA);
    endtask

    task automatic test_midframe_reset();
        fill_ramp();
        clear_mon();
        drive_a(0, 500, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compared += 3;
        if (a_out_valid !== 1'b0) begin failed++; $display("FAIL midreset_out_valid: got %b, expected 0", a_out_valid); end
        if (a_fd !== 1'b0)        begin failed++; $display("FAIL midreset_frame_done: got %b, expected 0", a_fd); end
        if (a_in_ready !== 1'b0)  begin failed++; $display("FAIL midreset_in_ready: got %b, expected 0", a_in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        drive_a(0, NPIX, 1'b1);
        check_frame("restart", 1'b0, 1, DA);
    endtask

    task automatic test_stride2();
        logic [WA-1:0] w;
        fill_ramp();
        clear_mon();
        drive_b();
        check_frame("stride2", 1'b1, 2, 1);
        w = (qb_win.size() > 15) ? qb_win[15] : '0;
        compared++;
        if (el(w, 0, 0, 0) !== 16'd66) begin failed++; $display("FAIL stride2_r1c1_e00: got %0d, expected 66", el(w, 0, 0, 0)); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_random();
        test_midframe_reset();
        test_stride2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
`default_nettype wire
